// File: rtl/push_pkg.sv
// Shared definitions for the push-rod motion profiler: FSM encoding and
// default ramp constants (frequencies in Hz, times in clk cycles).
package push_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_DONE
  } state_t;

  localparam int CLK_HZ            = 50_000_000;
  localparam int FRE_W             = 20;
  localparam int FRE_MIN_DEF       = 400;
  localparam int FRE_MAX_DEF       = 1600;
  localparam int FRE_STEP_DEF      = 50;
  localparam int RAMP_TICKS_DEF    = CLK_HZ / 100;   // 10 ms ramp tick
  localparam int TIMEOUT_TICKS_DEF = CLK_HZ / 10;    // 100 ms stall window

endpackage

// File: rtl/push_edge_sync.sv
// Brings the generator's PWM wave into the clk domain and emits a one-cycle
// pulse per rising edge. Two sync flops plus one history flop; the pulse is
// registered, so it appears three clocks after the edge is first sampled.
module push_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [2:0] sync_q;

  // Shift the raw input through the synchroniser and register the edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], d};
      rise   <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/push_fre_ramp.sv
// Trapezoidal motion profiler feeding the push-rod PWM frequency generator.
// Ramps fre from FRE_MIN to FRE_MAX and back, counts fed-back step pulses and
// pulses done on completion or abort.
// Optional: define PUSH_STALL_TIMEOUT_EN to add a stall watchdog that raises
// a sticky fault and aborts when no step arrives within TIMEOUT_TICKS.
module push_fre_ramp
  import push_pkg::*;
#(
  parameter int FRE_MIN       = FRE_MIN_DEF,
  parameter int FRE_MAX       = FRE_MAX_DEF,
  parameter int FRE_STEP      = FRE_STEP_DEF,
  parameter int RAMP_TICKS    = RAMP_TICKS_DEF,
  parameter int STEP_W        = 16,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [STEP_W-1:0] steps,
  input  logic              dir,
  input  logic              abort,
  input  logic              step_in,
  output logic [19:0]       fre,
  output logic              run,
  output logic              dir_out,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_cnt,
  output logic              fault
);

  localparam int TICK_W = $clog2(RAMP_TICKS + 1);

  state_t            state_q, state_nx;
  logic [FRE_W-1:0]  fre_nx, fre_inc, fre_dec;
  logic [FRE_W:0]    fre_sum;
  logic [STEP_W-1:0] steps_q, steps_nx, acc_q, acc_nx, cnt_nx, rem;
  logic              run_nx, dir_nx, busy_nx, done_nx, fault_nx;
  logic              armed_q, active, entry, tick, stall, step_rise, step_inc;
  logic [TICK_W-1:0] tick_cnt;

  push_edge_sync u_step_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (step_in),
    .rise  (step_rise)
  );

  assign active   = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);
  assign rem      = steps_q - step_cnt;
  assign step_inc = step_rise && active && (step_cnt != steps_q) && !abort && !stall;
  assign tick     = (tick_cnt == TICK_W'(RAMP_TICKS - 1));
  assign entry    = (state_nx != state_q);

  // Saturating ramp arithmetic; the extra sum bit keeps the add from wrapping.
  assign fre_sum = {1'b0, fre} + (FRE_W + 1)'(FRE_STEP);
  assign fre_inc = (fre_sum > (FRE_W + 1)'(FRE_MAX)) ? FRE_W'(FRE_MAX) : fre_sum[FRE_W-1:0];
  assign fre_dec = (fre < FRE_W'(FRE_MIN + FRE_STEP)) ? FRE_W'(FRE_MIN) : fre - FRE_W'(FRE_STEP);

  // Ramp tick timebase, restarted whenever the FSM changes state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tick_cnt <= '0;
    else if (entry || tick)  tick_cnt <= '0;
    else                     tick_cnt <= tick_cnt + 1'b1;
  end

`ifdef PUSH_STALL_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_TICKS + 1);
  logic [STALL_W-1:0] stall_cnt;

  assign stall = active && (stall_cnt == STALL_W'(TIMEOUT_TICKS - 1));

  // Stall watchdog: reloads on each counted step and on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    stall_cnt <= '0;
    else if (entry || step_inc)    stall_cnt <= '0;
    else if (active && !stall)     stall_cnt <= stall_cnt + 1'b1;
  end
`else
  // No watchdog in this build: stall can never fire.
  assign stall = 1'b0 & (TIMEOUT_TICKS > 0);
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      fre      <= '0;
      run      <= 1'b0;
      dir_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_cnt <= '0;
      fault    <= 1'b0;
      steps_q  <= '0;
      acc_q    <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_nx;
      fre      <= fre_nx;
      run      <= run_nx;
      dir_out  <= dir_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      step_cnt <= cnt_nx;
      fault    <= fault_nx;
      steps_q  <= steps_nx;
      acc_q    <= acc_nx;
      armed_q  <= 1'b1;
    end
  end

  // Next state / next outputs. Priority while moving: abort/stall, then
  // completion, then ramp decisions.
  always_comb begin
    state_nx = state_q;
    fre_nx   = fre;
    run_nx   = run;
    dir_nx   = dir_out;
    busy_nx  = busy;
    done_nx  = 1'b0;
    cnt_nx   = step_cnt;
    fault_nx = fault;
    steps_nx = steps_q;
    acc_nx   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start && armed_q) begin
          if (steps != '0) begin
            steps_nx = steps;
            dir_nx   = dir;
            cnt_nx   = '0;
            fre_nx   = FRE_W'(FRE_MIN);
            run_nx   = 1'b1;
            busy_nx  = 1'b1;
            fault_nx = 1'b0;
            state_nx = S_ACCEL;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      S_ACCEL, S_CRUISE, S_DECEL: begin
        if (abort || stall || (step_cnt == steps_q)) begin
          fre_nx   = '0;
          run_nx   = 1'b0;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          fault_nx = fault | stall;
          state_nx = S_DONE;
        end else begin
          if (step_inc) cnt_nx = step_cnt + 1'b1;
          case (state_q)
            S_ACCEL: begin
              if (fre == FRE_W'(FRE_MAX)) begin
                acc_nx   = step_cnt;
                state_nx = S_CRUISE;
              end else if (rem <= step_cnt) begin
                // Not enough distance left to reach cruise: triangle profile.
                acc_nx   = step_cnt;
                state_nx = S_DECEL;
              end else if (tick) begin
                fre_nx = fre_inc;
              end
            end
            S_CRUISE: if (rem <= acc_q) state_nx = S_DECEL;
            default:  if (tick) fre_nx = fre_dec;
          endcase
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_push_fre_ramp.sv
// Bench for push_fre_ramp with short ramp timing. A behavioural generator
// model produces step_in from fre; stimulus pushes expected move results into
// a scoreboard and a negedge monitor checks them whenever done pulses.
module tb_push_fre_ramp;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, dir = 1'b0, abort = 1'b0, step_in = 1'b0;
  logic [15:0] steps = '0;
  logic [19:0] fre;
  logic        run, dir_out, busy, done, fault;
  logic [15:0] step_cnt;

  push_fre_ramp #(
    .RAMP_TICKS    (10),
    .FRE_STEP      (400),
    .TIMEOUT_TICKS (200)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .steps (steps), .dir (dir),
    .abort (abort), .step_in (step_in), .fre (fre), .run (run), .dir_out (dir_out),
    .busy (busy), .done (done), .step_cnt (step_cnt), .fault (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt; int dir; int peak; int decel; int fault; int busy;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   vecs = 0, errs = 0, done_cnt = 0;
  bit   hold_low = 1'b0;

`ifdef PUSH_STALL_TIMEOUT_EN
  localparam int STALL_FAULT = 1;
`else
  localparam int STALL_FAULT = 0;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Generator model: phase accumulator toggling step_in at a rate set by fre.
  int ph = 0;
  always @(negedge clk) begin
    if (!run || hold_low) begin
      ph = 0; step_in = 1'b0;
    end else begin
      ph = ph + int'(fre);
      if (ph >= 1600) begin ph = ph - 1600; step_in = ~step_in; end
    end
  end

  // Monitor: track the profile between done pulses, check on each done.
  int peak = 0, prv = 0;
  bit saw_dec = 0, saw_busy = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      peak = 0; prv = 0; saw_dec = 0; saw_busy = 0;
    end else if (done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        vecs++; errs++;
        $display("FAIL unexpected_done: got done=1 expected no move pending (t=%0t)", $time);
      end else begin
        e = sbq.pop_front();
        chk("step_cnt", int'(step_cnt), e.cnt);
        chk("dir_out", int'(dir_out), e.dir);
        chk("peak_fre", peak, e.peak);
        chk("fault", int'(fault), e.fault);
        chk("saw_busy", int'(saw_busy), e.busy);
        chk("fre_at_done", int'(fre), 0);
        chk("run_at_done", int'(run), 0);
        chk("busy_at_done", int'(busy), 0);
        if (e.decel >= 0) chk("saw_decel", int'(saw_dec), e.decel);
      end
      peak = 0; prv = 0; saw_dec = 0; saw_busy = 0;
    end else begin
      if (busy || run) saw_busy = 1;
      if (int'(fre) > peak) peak = int'(fre);
      if (fre != 0 && prv != 0 && int'(fre) < prv) saw_dec = 1;
      prv = int'(fre);
    end
  end

  task automatic pulse_start(input int n, input bit d);
    @(negedge clk); steps = 16'(n); dir = d; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != c0) return;
      @(negedge clk); #1;
    end
    vecs++; errs++;
    $display("FAIL %s_timeout: got no done expected done within %0d cycles", nm, budget);
  endtask

  task automatic wait_cnt(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (int'(step_cnt) == n) return;
      @(negedge clk); #1;
    end
    vecs++; errs++;
    $display("FAIL cnt_timeout: got step_cnt=%0d expected %0d", step_cnt, n);
  endtask

  task automatic move(input exp_t x, input int n, input bit d, input int budget, input string nm);
    int c0;
    c0 = done_cnt;
    sbq.push_back(x);
    pulse_start(n, d);
    wait_done(c0, budget, nm);
  endtask

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: reset mid-move clears everything immediately
    pulse_start(100, 1'b1);
    repeat (20) @(negedge clk);
    chk("busy_before_reset", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_fre", int'(fre), 0);
    chk("rst_run", int'(run), 0);
    chk("rst_dir_out", int'(dir_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_step_cnt", int'(step_cnt), 0);
    chk("rst_fault", int'(fault), 0);
    // start in the very first cycle after release is ignored
    @(negedge clk); rst_n = 1'b1; steps = 16'd100; dir = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_after_release_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("start_after_release_run", int'(run), 0);

    // 2: full trapezoid, 100 steps dir=1
    move('{cnt: 100, dir: 1, peak: 1600, decel: 1, fault: 0, busy: 1}, 100, 1'b1, 3000, "full");
    // 3: short move stays triangular, never above 800
    move('{cnt: 4, dir: 0, peak: 800, decel: -1, fault: 0, busy: 1}, 4, 1'b0, 600, "triangle");
    // 4: zero-step request: done only, previous count and direction held
    move('{cnt: 4, dir: 0, peak: 0, decel: 0, fault: 0, busy: 0}, 0, 1'b1, 10, "zero");

    // 5: abort at step 30, with an ignored start while busy
    c0 = done_cnt;
    sbq.push_back('{cnt: 30, dir: 1, peak: 1600, decel: 0, fault: 0, busy: 1});
    pulse_start(100, 1'b1);
    wait_cnt(10, 2000);
    pulse_start(5, 1'b0);
    wait_cnt(30, 2000);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_done(c0, 10, "abort");
    repeat (5) @(negedge clk);
    chk("cnt_held_after_abort", int'(step_cnt), 30);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);

    // 6: stalled generator output
    hold_low = 1'b1;
    c0 = done_cnt;
    sbq.push_back('{cnt: 0, dir: 1, peak: 1600, decel: 0, fault: STALL_FAULT, busy: 1});
    pulse_start(20, 1'b1);
`ifdef PUSH_STALL_TIMEOUT_EN
    wait_done(c0, 400, "stall");
`else
    repeat (300) @(negedge clk);
    chk("no_stall_busy", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_done(c0, 10, "stall_abort");
`endif
    hold_low = 1'b0;
    repeat (2) @(negedge clk);
    chk("fault_sticky", int'(fault), STALL_FAULT);
    // next accepted start clears fault
    move('{cnt: 4, dir: 0, peak: 800, decel: -1, fault: 0, busy: 1}, 4, 1'b0, 600, "fault_clear");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
